// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the read-side memory arbiter: requester indices,
// index width carried in the AXI ID MSBs, and the AR holding-register entry.
package mem_read_arbiter_pkg;

   localparam int REQ_ICACHE = 0;
   localparam int REQ_DMISS  = 1;
   localparam int REQ_DUC    = 2;
   localparam int NREQ_DEF   = 3;

   localparam int IDX_W      = $clog2(NREQ_DEF);

   localparam int AR_ADDR_W  = 64;
   localparam int AR_LEN_W   = 8;
   localparam int AR_ID_W    = 6;

   typedef struct packed {
      logic [AR_ADDR_W-1:0] addr;
      logic [AR_LEN_W-1:0]  len;
      logic [AR_ID_W-1:0]   id;
   } ar_entry_t;

endpackage

// File: rtl/mem_read_arbiter_rr.sv
// Round-robin grant: the first eligible requester after rr_ptr wins.
// Purely combinational so it can be reused for a write-side arbiter.
module rr_arbiter
   import mem_read_arbiter_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  elig,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic             gnt_vld,
   output logic [PTR_W-1:0] gnt_idx
);

   logic [PTR_W-1:0] cand;

   // Scan from rr_ptr+1 around the ring and latch the first eligible index.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NREQ);
         if (!gnt_vld && elig[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI read address/data path between the icache refill, dcache
// miss and dcache uncached requesters. The requester index rides in the AR
// ID MSBs and steers returning R beats; each requester is limited to
// MAX_OUT outstanding bursts.
module mem_read_arbiter
   import mem_read_arbiter_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int ADDR_W  = AR_ADDR_W,
   parameter int DATA_W  = 512,
   parameter int ID_W    = AR_ID_W,
   parameter int LEN_W   = AR_LEN_W,
   parameter int MAX_OUT = 4
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [NREQ-1:0]               req_valid_i,
   output logic [NREQ-1:0]               req_ready_o,
   input  logic [NREQ*ADDR_W-1:0]        req_addr_i,
   input  logic [NREQ*LEN_W-1:0]         req_len_i,
   input  logic [NREQ*(ID_W-IDX_W)-1:0]  req_id_i,
   output logic                          ar_valid_o,
   input  logic                          ar_ready_i,
   output logic [ADDR_W-1:0]             ar_addr_o,
   output logic [LEN_W-1:0]              ar_len_o,
   output logic [ID_W-1:0]               ar_id_o,
   input  logic                          r_valid_i,
   output logic                          r_ready_o,
   input  logic [DATA_W-1:0]             r_data_i,
   input  logic [ID_W-1:0]               r_id_i,
   input  logic [1:0]                    r_resp_i,
   input  logic                          r_last_i,
   output logic [NREQ-1:0]               rsp_valid_o,
   input  logic [NREQ-1:0]               rsp_ready_i,
   output logic [DATA_W-1:0]             rsp_data_o,
   output logic [ID_W-IDX_W-1:0]         rsp_id_o,
   output logic [1:0]                    rsp_resp_o,
   output logic                          rsp_last_o,
   output logic                          err_o
);

   localparam int LID_W = ID_W - IDX_W;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [NREQ-1:0]  elig;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic             can_load;
   logic             req_hs;
   ar_entry_t        ld_entry;
   ar_entry_t        ar_entry_p0;
   logic             ar_vld_p0;
   logic [CNT_W-1:0] out_cnt [NREQ];
   logic [NREQ-1:0]  cnt_inc;
   logic [NREQ-1:0]  cnt_dec;
   logic [IDX_W-1:0] sel;
   logic             sel_ok;
   logic             r_last_hs;
   logic             err_q;

   // A requester competes only while it has a free outstanding-burst slot.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_valid_i[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
      end
   end

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (IDX_W)
   ) u_rr_arbiter (
      .elig    (elig),
      .rr_ptr  (rr_ptr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // The holding register can take a new entry when empty or draining this cycle.
   // Reset gates ready so nothing upstream sees a handshake that is discarded.
   always_comb begin
      can_load    = !ar_vld_p0 || ar_ready_i;
      req_hs      = rstn_i && gnt_vld && can_load;
      req_ready_o = '0;
      ld_entry    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            req_ready_o[i] = req_hs;
            ld_entry.addr  = req_addr_i[i*ADDR_W +: ADDR_W];
            ld_entry.len   = req_len_i[i*LEN_W +: LEN_W];
            ld_entry.id    = {gnt_idx, req_id_i[i*LID_W +: LID_W]};
         end
      end
   end

   // ---- stage p0: AR holding register ----
   // Load on request handshake, clear on AR handshake with nothing new behind it.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ar_vld_p0   <= 1'b0;
         ar_entry_p0 <= '0;
      end else if (req_hs) begin
         ar_vld_p0   <= 1'b1;
         ar_entry_p0 <= ld_entry;
      end else if (ar_ready_i) begin
         ar_vld_p0   <= 1'b0;
      end
   end

   assign ar_valid_o = ar_vld_p0;
   assign ar_addr_o  = ar_entry_p0.addr;
   assign ar_len_o   = ar_entry_p0.len;
   assign ar_id_o    = ar_entry_p0.id;

   // Round-robin pointer follows the last winner; reset to NREQ-1 so index 0 goes first.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rr_ptr <= IDX_W'(NREQ - 1);
      end else if (req_hs) begin
         rr_ptr <= gnt_idx;
      end
   end

   // R routing: the ID MSBs select the requester; unknown indices are swallowed.
   always_comb begin
      sel         = r_id_i[ID_W-1 -: IDX_W];
      sel_ok      = int'(sel) < NREQ;
      r_ready_o   = 1'b1;
      rsp_valid_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IDX_W'(i)) begin
            rsp_valid_o[i] = r_valid_i && rstn_i;
            r_ready_o      = rsp_ready_i[i];
         end
      end
      r_last_hs = r_valid_i && r_ready_o && r_last_i && sel_ok;
   end

   assign rsp_data_o = r_data_i;
   assign rsp_id_o   = r_id_i[LID_W-1:0];
   assign rsp_resp_o = r_resp_i;
   assign rsp_last_o = r_last_i;

   // Per-requester increment at request acceptance, decrement at last R beat.
   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int i = 0; i < NREQ; i++) begin
         cnt_inc[i] = req_hs && (gnt_idx == IDX_W'(i));
         cnt_dec[i] = r_last_hs && (sel == IDX_W'(i));
      end
   end

   // Outstanding-burst counters; eligibility already caps the increment at MAX_OUT.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NREQ; i++) begin
            out_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) begin
               out_cnt[i] <= out_cnt[i] + CNT_W'(1);
            end else if (cnt_dec[i] && !cnt_inc[i] && (out_cnt[i] != '0)) begin
               out_cnt[i] <= out_cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // Sticky error: an R beat carried a requester index that does not exist.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         err_q <= 1'b0;
      end else if (r_valid_i && !sel_ok) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed scenarios plus a randomized phase for mem_read_arbiter, checked
// against a transaction-level reference model kept in this bench.
module tb_mem_read_arbiter;
   import mem_read_arbiter_pkg::*;

   localparam int NREQ    = 3;
   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 512;
   localparam int ID_W    = 6;
   localparam int LEN_W   = 8;
   localparam int MAX_OUT = 4;
   localparam int LID_W   = ID_W - IDX_W;

   logic                      clk_i = 1'b0;
   logic                      rstn_i;
   logic [NREQ-1:0]           req_valid_i;
   logic [NREQ-1:0]           req_ready_o;
   logic [NREQ*ADDR_W-1:0]    req_addr_i;
   logic [NREQ*LEN_W-1:0]     req_len_i;
   logic [NREQ*LID_W-1:0]     req_id_i;
   logic                      ar_valid_o;
   logic                      ar_ready_i;
   logic [ADDR_W-1:0]         ar_addr_o;
   logic [LEN_W-1:0]          ar_len_o;
   logic [ID_W-1:0]           ar_id_o;
   logic                      r_valid_i;
   logic                      r_ready_o;
   logic [DATA_W-1:0]         r_data_i;
   logic [ID_W-1:0]           r_id_i;
   logic [1:0]                r_resp_i;
   logic                      r_last_i;
   logic [NREQ-1:0]           rsp_valid_o;
   logic [NREQ-1:0]           rsp_ready_i;
   logic [DATA_W-1:0]         rsp_data_o;
   logic [LID_W-1:0]          rsp_id_o;
   logic [1:0]                rsp_resp_o;
   logic                      rsp_last_o;
   logic                      err_o;

   mem_read_arbiter #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .ID_W(ID_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_id_i(req_id_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_id_o(ar_id_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
      .r_id_i(r_id_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
      .rsp_resp_o(rsp_resp_o), .rsp_last_o(rsp_last_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model state: outstanding bursts per requester, last winner,
   // contents of the pending AR, sticky error.
   int          m_out [NREQ];
   int          m_ptr;
   bit          m_full;
   logic [63:0] m_addr;
   logic [7:0]  m_len;
   logic [5:0]  m_id;
   bit          m_err;

   int ar_ids [$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner();
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (m_ptr + k) % NREQ;
         if (req_valid_i[c] && m_out[c] < MAX_OUT) return c;
      end
      return -1;
   endfunction

   task automatic check_outputs();
      int w;
      int sel;
      logic [NREQ-1:0] er;
      logic [NREQ-1:0] ev;
      logic erdy;
      w   = winner();
      sel = int'(r_id_i[ID_W-1 -: IDX_W]);
      er  = '0;
      ev  = '0;
      if (w >= 0 && (!m_full || ar_ready_i)) er[w] = 1'b1;
      chk("req_ready", 512'(req_ready_o), 512'(er));
      chk("ar_valid", 512'(ar_valid_o), 512'(m_full));
      chk("ar_addr", 512'(ar_addr_o), 512'(m_addr));
      chk("ar_len", 512'(ar_len_o), 512'(m_len));
      chk("ar_id", 512'(ar_id_o), 512'(m_id));
      erdy = 1'b1;
      if (sel < NREQ) begin
         ev[sel] = r_valid_i;
         erdy    = rsp_ready_i[sel];
      end
      chk("rsp_valid", 512'(rsp_valid_o), 512'(ev));
      chk("r_ready", 512'(r_ready_o), 512'(erdy));
      chk("rsp_data", rsp_data_o, r_data_i);
      chk("rsp_id", 512'(rsp_id_o), 512'(r_id_i[LID_W-1:0]));
      chk("rsp_resp", 512'(rsp_resp_o), 512'(r_resp_i));
      chk("rsp_last", 512'(rsp_last_o), 512'(r_last_i));
      chk("err", 512'(err_o), 512'(m_err));
      if (ar_valid_o && ar_ready_i) ar_ids.push_back(int'(ar_id_o[ID_W-1 -: IDX_W]));
   endtask

   task automatic model_update();
      int w;
      int sel;
      logic [1:0] wi;
      if (!rstn_i) begin
         for (int i = 0; i < NREQ; i++) m_out[i] = 0;
         m_ptr  = NREQ - 1;
         m_full = 0;
         m_addr = '0;
         m_len  = '0;
         m_id   = '0;
         m_err  = 0;
      end else begin
         w   = winner();
         sel = int'(r_id_i[ID_W-1 -: IDX_W]);
         if (w >= 0 && (!m_full || ar_ready_i)) begin
            wi = 2'(w);
            m_out[w]++;
            m_ptr  = w;
            m_full = 1;
            m_addr = req_addr_i[w*ADDR_W +: ADDR_W];
            m_len  = req_len_i[w*LEN_W +: LEN_W];
            m_id   = {wi, req_id_i[w*LID_W +: LID_W]};
         end else if (ar_ready_i) begin
            m_full = 0;
         end
         if (r_valid_i && sel < NREQ && rsp_ready_i[sel] && r_last_i) m_out[sel]--;
         if (r_valid_i && sel >= NREQ) m_err = 1;
      end
   endtask

   task automatic rand_payload();
      for (int i = 0; i < NREQ; i++) begin
         req_addr_i[i*ADDR_W +: ADDR_W] = {$urandom(), $urandom()};
         req_len_i[i*LEN_W +: LEN_W]    = 8'($urandom());
         req_id_i[i*LID_W +: LID_W]     = 4'($urandom());
      end
      for (int j = 0; j < DATA_W / 32; j++) r_data_i[j*32 +: 32] = $urandom();
      r_resp_i = 2'($urandom());
   endtask

   // One clock: fresh payload, compare at mid-cycle, advance model, cross the edge.
   task automatic step();
      rand_payload();
      #4;
      if (rstn_i) check_outputs();
      model_update();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rstn_i      = 1'b0;
      req_valid_i = '0;
      ar_ready_i  = 1'b0;
      r_valid_i   = 1'b0;
      r_id_i      = '0;
      r_last_i    = 1'b0;
      rsp_ready_i = '1;
      step();
      step();
      req_valid_i = '1;
      r_valid_i   = 1'b1;
      #2;
      chk("rst_req_ready", 512'(req_ready_o), 512'(0));
      chk("rst_rsp_valid", 512'(rsp_valid_o), 512'(0));
      chk("rst_ar_valid", 512'(ar_valid_o), 512'(0));
      chk("rst_err", 512'(err_o), 512'(0));
      req_valid_i = '0;
      r_valid_i   = 1'b0;
      step();
      rstn_i = 1'b1;
   endtask

   logic [ADDR_W-1:0] s_addr;
   logic [LEN_W-1:0]  s_len;
   logic [ID_W-1:0]   s_id;
   int                bi;
   int                got [NREQ];
   int                bsel [8];

   initial begin
      rand_payload();
      do_reset();

      // Round-robin order with every requester asking and AR always ready.
      ar_ids.delete();
      req_valid_i = 3'b111;
      ar_ready_i  = 1'b1;
      repeat (5) step();
      chk("ar_count", 512'(ar_ids.size()), 512'(4));
      chk("ar_seq0", 512'(ar_ids.size() > 0 ? ar_ids[0] : -1), 512'(0));
      chk("ar_seq1", 512'(ar_ids.size() > 1 ? ar_ids[1] : -1), 512'(1));
      chk("ar_seq2", 512'(ar_ids.size() > 2 ? ar_ids[2] : -1), 512'(2));
      chk("ar_seq3", 512'(ar_ids.size() > 3 ? ar_ids[3] : -1), 512'(0));

      // AR stall: pending entry must hold steady, no request accepted.
      ar_ready_i = 1'b0;
      step();
      s_addr = ar_addr_o;
      s_len  = ar_len_o;
      s_id   = ar_id_o;
      repeat (5) step();
      chk("stall_addr", 512'(ar_addr_o), 512'(s_addr));
      chk("stall_len", 512'(ar_len_o), 512'(s_len));
      chk("stall_id", 512'(ar_id_o), 512'(s_id));
      chk("stall_ready", 512'(req_ready_o), 512'(0));
      chk("stall_valid", 512'(ar_valid_o), 512'(1));

      // Outstanding limit on requester 1, released by a last beat one cycle later.
      do_reset();
      req_valid_i = 3'b010;
      ar_ready_i  = 1'b1;
      repeat (4) step();
      #1;
      chk("limit_block", 512'(req_ready_o), 512'(0));
      step();
      r_valid_i = 1'b1;
      r_id_i    = {2'd1, 4'h5};
      r_last_i  = 1'b1;
      #1;
      chk("limit_same_cycle", 512'(req_ready_o), 512'(0));
      chk("limit_r_ready", 512'(r_ready_o), 512'(1));
      chk("limit_rsp_valid", 512'(rsp_valid_o), 512'(3'b010));
      step();
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      #1;
      chk("limit_release", 512'(req_ready_o), 512'(3'b010));
      step();

      // Interleaved bursts to requesters 0 and 2 with requester 2 back-pressuring.
      do_reset();
      req_valid_i = 3'b101;
      ar_ready_i  = 1'b1;
      repeat (2) step();
      req_valid_i = '0;
      for (int k = 0; k < 8; k++) bsel[k] = (k % 2 == 0) ? 0 : 2;
      for (int i = 0; i < NREQ; i++) got[i] = 0;
      bi = 0;
      for (int cyc = 0; cyc < 20 && bi < 8; cyc++) begin
         r_valid_i   = 1'b1;
         r_id_i      = {2'(bsel[bi]), (bsel[bi] == 0) ? 4'h3 : 4'hA};
         r_last_i    = (bi >= 6);
         rsp_ready_i = (cyc == 3 || cyc == 4) ? 3'b011 : 3'b111;
         #1;
         if (bsel[bi] == 2 && !rsp_ready_i[2]) chk("il_stall_ready", 512'(r_ready_o), 512'(0));
         for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid_o[i] && rsp_ready_i[i]) begin
               got[i]++;
               chk("il_local_id", 512'(rsp_id_o), 512'((i == 0) ? 4'h3 : 4'hA));
            end
         end
         if (bsel[bi] == 0 || rsp_ready_i[2]) bi++;
         step();
      end
      r_valid_i   = 1'b0;
      r_last_i    = 1'b0;
      rsp_ready_i = '1;
      chk("il_done", 512'(bi), 512'(8));
      chk("il_beats0", 512'(got[0]), 512'(4));
      chk("il_beats1", 512'(got[1]), 512'(0));
      chk("il_beats2", 512'(got[2]), 512'(4));
      req_valid_i = 3'b101;
      repeat (3) step();
      req_valid_i = '0;

      // Beat with a nonexistent requester index.
      do_reset();
      r_valid_i = 1'b1;
      r_id_i    = {2'd3, 4'h1};
      r_last_i  = 1'b1;
      #1;
      chk("bad_rsp_valid", 512'(rsp_valid_o), 512'(0));
      chk("bad_r_ready", 512'(r_ready_o), 512'(1));
      step();
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      #1;
      chk("bad_err_set", 512'(err_o), 512'(1));
      repeat (3) step();
      chk("bad_err_sticky", 512'(err_o), 512'(1));
      do_reset();
      #1;
      chk("bad_err_cleared", 512'(err_o), 512'(0));

      // Simultaneous acceptance and last beat on requester 0 at count 2.
      req_valid_i = 3'b001;
      ar_ready_i  = 1'b1;
      repeat (2) step();
      r_valid_i = 1'b1;
      r_id_i    = {2'd0, 4'h2};
      r_last_i  = 1'b1;
      #1;
      chk("sim_req_ready", 512'(req_ready_o), 512'(3'b001));
      step();
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      repeat (2) step();
      #1;
      chk("sim_count_full", 512'(req_ready_o), 512'(0));
      step();

      // Randomized traffic against the model.
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         int c;
         req_valid_i = 3'($urandom());
         ar_ready_i  = ($urandom_range(0, 3) != 0);
         rsp_ready_i = 3'($urandom()) | 3'($urandom());
         c = $urandom_range(0, NREQ - 1);
         r_valid_i = 1'b0;
         r_last_i  = 1'b0;
         if ($urandom_range(0, 99) == 0) begin
            r_valid_i = 1'b1;
            r_id_i    = {2'd3, 4'($urandom())};
         end else if (m_out[c] > 0 && $urandom_range(0, 1) == 1) begin
            r_valid_i = 1'b1;
            r_id_i    = {2'(c), 4'($urandom())};
            r_last_i  = ($urandom_range(0, 2) == 0);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single upstream AXI read-address/read-data path between the core's read requesters: icache refill, dcache miss-read and dcache uncached read. It sits between the core memory interfaces and the AXI master port, ahead of the atomics stage.
- Arbitration is round-robin.
- The requester index is stamped into the AXI ID MSBs.
- R beats are routed back by that index.
- Outstanding bursts are bounded per requester.

## Interface
Parameters:
- NREQ, 3, number of requesters (index 0 = icache, 1 = dcache miss, 2 = dcache uncached)
- ADDR_W, 64, address width
- DATA_W, 512, R data width
- ID_W, 6, AXI ID width; top IDX_W = clog2(NREQ) bits carry the requester index
- LEN_W, 8, AXI burst length width
- MAX_OUT, 4, maximum outstanding bursts per requester

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; **one clock; reset is synchronous and active-low**
- req_valid_i  in  NREQ  read request valid, per requester
- req_ready_o  out  NREQ  request accepted
- req_addr_i  in  NREQ x ADDR_W  burst start address
- req_len_i  in  NREQ x LEN_W  AXI len (beats - 1)
- req_id_i  in  NREQ x (ID_W-IDX_W)  requester-local transaction ID
- ar_valid_o  out  1  AR valid
- ar_ready_i  in  1  AR ready
- ar_addr_o  out  ADDR_W  AR address
- ar_len_o  out  LEN_W  AR length
- ar_id_o  out  ID_W  AR ID = {index, local ID}
- r_valid_i  in  1  R valid
- r_ready_o  out  1  R ready
- r_data_i  in  DATA_W  R data
- r_id_i  in  ID_W  R ID
- r_resp_i  in  2  R response code
- r_last_i  in  1  last beat of the burst
- rsp_valid_o  out  NREQ  per-requester R valid
- rsp_ready_i  in  NREQ  per-requester R ready
- rsp_data_o  out  DATA_W  shared R data
- rsp_id_o  out  ID_W-IDX_W  local ID
- rsp_resp_o  out  2  response code
- rsp_last_o  out  1  last beat
- err_o  out  1  sticky flag: R beat arrived with an invalid requester index

## Operation
- **Eligibility.** Requester i is eligible when req_valid_i[i] is high and out_cnt[i] < MAX_OUT.
- **Arbitration.** Round-robin among eligible requesters.
  - Search starts at rr_ptr + 1, modulo NREQ.
  - rr_ptr updates to the winner on each request handshake.
- **AR holding register.** The AR channel is driven from a one-entry register (ar_full).
  - The winner gets req_ready_o[w] = 1 when ar_full = 0, or when ar_full = 1 and ar_ready_i = 1 (back-to-back issue).
  - On a request handshake the register loads addr, len and {w, id}, and ar_full is set.
  - On an AR handshake with no new load, ar_full is cleared.
  - While ar_full = 1 and ar_ready_i = 0, all AR outputs are stable.
- **Outstanding counters.** out_cnt[i] has width clog2(MAX_OUT + 1).
  - Increments on a request handshake (not at AR issue).
  - Decrements on an R handshake with r_last_i = 1 and index i.
  - Simultaneous increment and decrement: value unchanged.
  - The counter never exceeds MAX_OUT and never underflows.
- **R routing.** sel = r_id_i[ID_W-1 -: IDX_W].
  - When sel < NREQ: rsp_valid_o[sel] = r_valid_i and r_ready_o = rsp_ready_i[sel]. Data, resp, last and local ID pass through combinationally.
  - When sel >= NREQ: the beat is dropped (r_ready_o = 1, all rsp_valid_o = 0) and err_o is set until reset.
  - R beats from different requesters may interleave; routing is per beat.
- **Reset.** All outputs and state reset to 0: ar_valid_o = 0, req_ready_o = 0, rsp_valid_o = 0, err_o = 0, out_cnt = 0, rr_ptr = NREQ-1 (so requester 0 wins first).

## Timing
- Request to ar_valid_o: 1 cycle. A handshake in cycle N gives ar_valid_o = 1 in cycle N+1.
- Sustained throughput: one AR per cycle while ar_ready_i stays high.
- R path: 0-cycle combinational passthrough, no buffering.
- req_ready_o depends combinationally on ar_ready_i, req_valid_i and out_cnt.
- A counter at MAX_OUT that is decremented in cycle N makes that requester eligible in cycle N+1, not in the same cycle.
- Reset asserted mid-burst clears all state. The upstream slave must be reset together with this block.

## Structure
- Shared package holds:
  - the requester index constants REQ_ICACHE = 0, REQ_DMISS = 1, REQ_DUC = 2;
  - IDX_W;
  - the ar_entry_t struct (addr, len, id).
- One sub-module: rr_arbiter (NREQ-wide round-robin grant from an eligibility vector and rr_ptr), kept reusable for a write-side arbiter.

## Test plan
- Reset release, then req_valid_i = 3'b111 held with ar_ready_i = 1 → AR IDs issue in index order 0, 1, 2, 0; rr_ptr cycles; one AR per cycle.
- ar_ready_i = 0 for 5 cycles while ar_full → ar_addr_o, ar_len_o and ar_id_o are unchanged, and req_ready_o = 0 for all requesters.
- Requester 1 issues 4 bursts with no R returned (MAX_OUT = 4) → 5th request blocked. R last beat for index 1 → request accepted in the next cycle.
- Interleaved 4-beat R bursts for index 0 and index 2, with rsp_ready_i[2] = 0 for 2 cycles → r_ready_o drops only during index-2 beats, and every beat reaches the correct requester with the correct local ID.
- R beat with index 3 (NREQ = 3) → beat consumed, no rsp_valid_o asserted, err_o = 1 until reset.
- Simultaneous request handshake and last-beat handshake on the same requester with out_cnt = 2 → out_cnt stays 2.
